serial_addsub_n: RTL and testbench



---
 rtl/serial_addsub_n_pkg.sv | 18 +
 rtl/serial_addsub_n_shift_reg_pl.sv | 43 ++++
 rtl/serial_addsub_n.sv | 151 +++++++++++++++
 tb/tb_serial_addsub_n.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_n_pkg.sv
// Shared constants and helpers for the bit-serial adder/subtractor.
package serial_addsub_n_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Operation mode, captured from the sub input at start
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Full-adder carry: majority of the three inputs
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_addsub_n_shift_reg_pl.sv
// WIDTH-bit right-shift register with parallel load, serial input at the MSB,
// shift enable and asynchronous active-low clear. Load has priority over shift.
module shift_reg_pl
    import serial_addsub_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection: load, shift right, or hold
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (shift_en) begin
            q_d = {ser_in, q_q[WIDTH-1:1]};
        end else begin
            q_d = q_q;
        end
    end

    // Register with asynchronous clear
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial adder/subtractor. Operands load in parallel, then one bit per
// clock is processed LSB-first; the sum shifts back into the A register.
// Subtraction is A + ~B + 1: B is inverted bit by bit and the +1 enters as
// the initial carry.
module serial_addsub_n
    import serial_addsub_n_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             load_s;
    logic             shift_s;
    logic             bb_s;
    logic             s_s;
    logic             carry_new_s;
    logic             last_s;
    logic             b_hi_unused_s;

    // Only B's LSB is consumed; higher bits reach it as the register shifts.
    assign b_hi_unused_s = ^b_q[WIDTH-1:1];

    // One full-adder slice plus control decodes
    always_comb begin
        bb_s        = b_q[0] ^ (mode_q == MODE_SUB);
        s_s         = a_q[0] ^ bb_s ^ carry_q;
        carry_new_s = maj3(a_q[0], bb_s, carry_q);
        last_s      = (cnt_q == LAST_CNT);
        shift_s     = (state_q == ST_SHIFT);
        load_s      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    shift_reg_pl #(.WIDTH(WIDTH)) u_a_reg (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (load_s),
        .load_val (a),
        .shift_en (shift_s),
        .ser_in   (s_s),
        .q        (a_q)
    );

    shift_reg_pl #(.WIDTH(WIDTH)) u_b_reg (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (load_s),
        .load_val (b),
        .shift_en (shift_s),
        .ser_in   (1'b0),
        .q        (b_q)
    );

    // FSM, carry, bit counter and result capture
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    carry_d = sub;
                    mode_d  = sub;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                carry_d = carry_new_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_s) begin
                    // MSB slice: overflow when carry into and out of it differ
                    ovf_d   = carry_q ^ carry_new_s;
                    cout_d  = carry_new_s;
                    sum_d   = {s_s, a_q[WIDTH-1:1]};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q <= ST_IDLE;
            carry_q <= 1'b0;
            mode_q  <= MODE_ADD;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Self-checking bench for serial_addsub_n: vector table plus scoreboard for
// WIDTH=8, hand-written back-to-back and mid-operation clear sequences, and
// a WIDTH=4 instance.
module tb_serial_addsub_n;

    logic       clk = 1'b0;
    logic       clear_b;
    logic       start, sub;
    logic [7:0] a, b;
    logic       busy, done, carry_out, overflow;
    logic [7:0] sum;

    logic       start4, sub4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    serial_addsub_n #(.WIDTH(8)) dut8 (
        .clk(clk), .clear_b(clear_b), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    serial_addsub_n #(.WIDTH(4)) dut4 (
        .clk(clk), .clear_b(clear_b), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4), .overflow(ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] r, input logic c, input logic v);
        vec_t t;
        t.sub = s; t.a = x; t.b = y;
        t.exp.sum = r; t.exp.cout = c; t.exp.ovf = v;
        return t;
    endfunction

    // Reference model: wide arithmetic with sign-based overflow detection
    function automatic exp_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
        exp_t       e;
        logic [7:0] yy;
        logic [8:0] full;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {8'd0, s};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (x[7] == yy[7]) && (full[7] != x[7]);
        return e;
    endfunction

    // Called at a negedge; returns at the first negedge after start is sampled
    task automatic start_op(input logic s, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        start = 1'b1; sub = s; a = x; b = y;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles, then compares the done-cycle outputs with the scoreboard
    task automatic wait_done(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("%s busy_cycles", name), 32'(n), 32'd8);
        check($sformatf("%s done", name), 32'(done), 32'd1);
        if (sb_q.size() == 0) begin
            check($sformatf("%s scoreboard_nonempty", name), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            check($sformatf("%s sum", name), 32'(sum), 32'(e.sum));
            check($sformatf("%s carry_out", name), 32'(carry_out), 32'(e.cout));
            check($sformatf("%s overflow", name), 32'(overflow), 32'(e.ovf));
        end
    endtask

    initial begin
        vec_t tbl[7];
        int   n;
        int   seen;
        logic [3:0] va4[2], vb4[2], vs4[2];
        logic       vc4[2], vv4[2];

        tbl[0] = mk(1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1);
        tbl[1] = mk(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        tbl[2] = mk(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        tbl[4] = mk(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        tbl[5] = mk(1'b1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0);
        tbl[6] = mk(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

        clear_b = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
        start4 = 1'b0; sub4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        last_exp = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst carry_out", 32'(carry_out), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst4 sum", 32'(sum4), 32'd0);
        clear_b = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].exp);
            wait_done($sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", i), 32'(done), 32'd0);
            check($sformatf("vec%0d idle_busy", i), 32'(busy), 32'd0);
        end

        // Random vectors against the model
        for (int i = 0; i < 4; i++) begin
            logic       rs;
            logic [7:0] rx, ry;
            rs = 1'($urandom_range(0, 1));
            rx = 8'($urandom);
            ry = 8'($urandom);
            start_op(rs, rx, ry, model(rs, rx, ry));
            wait_done($sformatf("rnd%0d", i));
            @(negedge clk);
        end

        // Back-to-back: inputs toggled while busy, restart in the DONE cycle
        start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
        sb_q.push_back(exp_t'({8'h46, 1'b0, 1'b0}));
        @(posedge clk);
        @(negedge clk);
        check("b2b sum_held", 32'(sum), 32'(last_exp.sum));
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            start = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            a     = 8'($urandom);
            b     = 8'($urandom);
            n++;
            @(negedge clk);
        end
        check("b2b first busy_cycles", 32'(n), 32'd8);
        check("b2b first done", 32'(done), 32'd1);
        if (sb_q.size() != 0) begin
            last_exp = sb_q.pop_front();
        end
        check("b2b first sum", 32'(sum), 32'(last_exp.sum));
        start = 1'b1; sub = 1'b0; a = 8'h01; b = 8'h01;
        sb_q.push_back(exp_t'({8'h02, 1'b0, 1'b0}));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b restart busy", 32'(busy), 32'd1);
        check("b2b restart done_low", 32'(done), 32'd0);
        wait_done("b2b second");
        @(negedge clk);

        // Mid-operation clear: outputs drop at once, no done pulse
        start = 1'b1; sub = 1'b0; a = 8'h0F; b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 clear_b = 1'b0;
        #1;
        check("clr busy", 32'(busy), 32'd0);
        check("clr done", 32'(done), 32'd0);
        check("clr sum", 32'(sum), 32'd0);
        check("clr carry_out", 32'(carry_out), 32'd0);
        check("clr overflow", 32'(overflow), 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        clear_b = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("clr no_done_pulse", 32'(seen), 32'd0);
        start_op(1'b0, 8'h0F, 8'h01, exp_t'({8'h10, 1'b0, 1'b0}));
        wait_done("post_clr");
        @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        // WIDTH=4 instance
        va4[0] = 4'b1010; vb4[0] = 4'b0011; vs4[0] = 4'b1101; vc4[0] = 1'b0; vv4[0] = 1'b0;
        va4[1] = 4'b0111; vb4[1] = 4'b0001; vs4[1] = 4'b1000; vc4[1] = 1'b0; vv4[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start4 = 1'b1; sub4 = 1'b0; a4 = va4[i]; b4 = vb4[i];
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0;
            n = 0;
            while (busy4 === 1'b1 && n < 64) begin
                n++;
                @(negedge clk);
            end
            check($sformatf("w4_%0d busy_cycles", i), 32'(n), 32'd4);
            check($sformatf("w4_%0d done", i), 32'(done4), 32'd1);
            check($sformatf("w4_%0d sum", i), 32'(sum4), 32'(vs4[i]));
            check($sformatf("w4_%0d carry_out", i), 32'(cout4), 32'(vc4[i]));
            check($sformatf("w4_%0d overflow", i), 32'(ovf4), 32'(vv4[i]));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
